// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared opcodes, ALU/mux encodings and state encoding for the
//               multicycle MIPS control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    localparam int ST_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_RT      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_outputs.sv
// ============================================================================
// Module      : mips_ctrl_outputs
// Description : Moore decode of FSM state into the datapath control vector.
//               Optional macro MIPS_CTRL_ADDI_EN enables the ADDI states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_ctrl_outputs
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_i_or_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_pc_source,
    output logic [1:0] o_aluop
);

    state_e w_st;
    assign w_st = state_e'(i_state);

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_i_or_d        = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = ALUB_RT;
        o_pc_source     = PCSRC_ALU;
        o_aluop         = ALUOP_ADD;
        case (w_st)
            // FETCH pc_write/ir_write depend on mem_ready and live in the top
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = ALUB_FOUR;
            end
            S_DECODE: o_alu_src_b = ALUB_IMM_SH2;
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                o_mem_read = 1'b1;
                o_i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_mem_write = 1'b1;
                o_i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                o_alu_src_a = 1'b1;
                o_aluop     = ALUOP_FUNCT;
            end
            S_R_WB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_aluop         = ALUOP_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = PCSRC_JUMP;
            end
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALUB_IMM;
            end
            S_ADDI_WB: o_reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multicycle MIPS main control FSM (state register, next-state
//               logic, FETCH handshake gating). Macro MIPS_CTRL_ADDI_EN adds addi.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter int OPCODE_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [1:0]          aluop,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  dbg_state
);

    state_e r_state_q;
    state_e w_state_d;
    logic   w_illegal;
    logic   w_dec_pc_write;
    logic   w_fetch_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state_q <= S_FETCH;
        else       r_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = S_FETCH;
        w_illegal = 1'b0;
        case (r_state_q)
            S_FETCH:  w_state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_state_d = S_MEM_ADDR;
                    OP_RTYPE:     w_state_d = S_R_EXEC;
                    OP_BEQ:       w_state_d = S_BRANCH;
                    OP_J:         w_state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      w_state_d = S_ADDI_EX;
`endif
                    default:      w_illegal = 1'b1;
                endcase
            end
            // Anything other than a store falls back to the harmless read path
            S_MEM_ADDR: w_state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   w_state_d = S_R_WB;
`ifdef MIPS_CTRL_ADDI_EN
            S_ADDI_EX:  w_state_d = S_ADDI_WB;
`endif
            default:    w_state_d = S_FETCH;
        endcase
    end

    mips_ctrl_outputs u_outputs (
        .i_state         (r_state_q),
        .o_pc_write      (w_dec_pc_write),
        .o_pc_write_cond (pc_write_cond),
        .o_i_or_d        (i_or_d),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_mem_to_reg    (mem_to_reg),
        .o_reg_dst       (reg_dst),
        .o_reg_write     (reg_write),
        .o_alu_src_a     (alu_src_a),
        .o_alu_src_b     (alu_src_b),
        .o_pc_source     (pc_source),
        .o_aluop         (aluop)
    );

    // Reset masks the fetch handshake so no PC/IR load can slip through
    assign w_fetch_go = (r_state_q == S_FETCH) & mem_ready & ~reset;
    assign pc_write   = w_dec_pc_write | w_fetch_go;
    assign ir_write   = w_fetch_go;
    assign illegal_op = w_illegal;
    assign dbg_state  = STATE_W'(r_state_q);

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Directed self-checking bench for mips_multicycle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source, aluop;
    logic [3:0] dbg_state;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.STATE_W(4), .OPCODE_W(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .aluop(aluop), .illegal_op(illegal_op), .dbg_state(dbg_state)
    );

    // state | pw pwc iod mr mw irw m2r rd rw asa | asb | pcs | aop | ill
    logic [20:0] obs;
    assign obs = {dbg_state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, pc_source, aluop, illegal_op};

    localparam logic [20:0] E_FETCH0 = 21'b0000_0001000000_01_00_00_0;
    localparam logic [20:0] E_FETCH1 = 21'b0000_1001010000_01_00_00_0;
    localparam logic [20:0] E_DEC    = 21'b0001_0000000000_11_00_00_0;
    localparam logic [20:0] E_DECILL = 21'b0001_0000000000_11_00_00_1;
    localparam logic [20:0] E_MADDR  = 21'b0010_0000000001_10_00_00_0;
    localparam logic [20:0] E_MRD    = 21'b0011_0011000000_00_00_00_0;
    localparam logic [20:0] E_MWB    = 21'b0100_0000001010_00_00_00_0;
    localparam logic [20:0] E_MWR    = 21'b0101_0010100000_00_00_00_0;
    localparam logic [20:0] E_REXEC  = 21'b0110_0000000001_00_00_10_0;
    localparam logic [20:0] E_RWB    = 21'b0111_0000000110_00_00_00_0;
    localparam logic [20:0] E_BR     = 21'b1000_0100000001_00_01_01_0;
    localparam logic [20:0] E_JMP    = 21'b1001_1000000000_00_10_00_0;
    localparam logic [20:0] E_AEX    = 21'b1010_0000000001_10_00_00_0;
    localparam logic [20:0] E_AWB    = 21'b1011_0000000010_00_00_00_0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;
        repeat (2) step();
        if (obs !== E_FETCH0) begin bad++; $display("FAIL reset_held got=%b exp=%b", obs, E_FETCH0); end
        total++;
        mem_ready = 1'b1; #1;
        if (obs !== E_FETCH0) begin bad++; $display("FAIL reset_ready_masked got=%b exp=%b", obs, E_FETCH0); end
        total++;
        mem_ready = 1'b0; reset = 1'b0; #1;
        if (obs !== E_FETCH0) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, E_FETCH0); end
        total++;
        step();
        if (obs !== E_FETCH0) begin bad++; $display("FAIL fetch_stall got=%b exp=%b", obs, E_FETCH0); end
        total++;
    endtask

    task automatic test_rtype();
        logic [20:0] exp_seq [5];
        exp_seq = '{E_FETCH1, E_DEC, E_REXEC, E_RWB, E_FETCH1};
        opcode = 6'b000000; mem_ready = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            if (obs !== exp_seq[i]) begin bad++; $display("FAIL rtype_c%0d got=%b exp=%b", i, obs, exp_seq[i]); end
            total++;
            if (i < 4) step();
        end
    endtask

    task automatic test_lw_stall();
        opcode = 6'b100011; mem_ready = 1'b1; #1;
        step();
        if (obs !== E_DEC) begin bad++; $display("FAIL lw_decode got=%b exp=%b", obs, E_DEC); end
        total++;
        step();
        if (obs !== E_MADDR) begin bad++; $display("FAIL lw_addr got=%b exp=%b", obs, E_MADDR); end
        total++;
        mem_ready = 1'b0;
        step();
        opcode = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            if (obs !== E_MRD) begin bad++; $display("FAIL lw_stall_c%0d got=%b exp=%b", i, obs, E_MRD); end
            total++;
            step();
        end
        mem_ready = 1'b1; #1;
        if (obs !== E_MRD) begin bad++; $display("FAIL lw_rd_last got=%b exp=%b", obs, E_MRD); end
        total++;
        step();
        if (obs !== E_MWB) begin bad++; $display("FAIL lw_wb got=%b exp=%b", obs, E_MWB); end
        total++;
        step();
        if (obs !== E_FETCH1) begin bad++; $display("FAIL lw_done got=%b exp=%b", obs, E_FETCH1); end
        total++;
    endtask

    task automatic test_sw();
        logic [20:0] exp_seq [5];
        exp_seq = '{E_FETCH1, E_DEC, E_MADDR, E_MWR, E_FETCH1};
        opcode = 6'b101011; mem_ready = 1'b1; #1;
        for (int i = 0; i < 5; i++) begin
            if (obs !== exp_seq[i]) begin bad++; $display("FAIL sw_c%0d got=%b exp=%b", i, obs, exp_seq[i]); end
            total++;
            if (i < 4) step();
        end
    endtask

    task automatic test_branch_jump();
        opcode = 6'b000100; mem_ready = 1'b1; #1;
        step(); step();
        if (obs !== E_BR) begin bad++; $display("FAIL beq_exec got=%b exp=%b", obs, E_BR); end
        total++;
        opcode = 6'b000010;
        step();
        if (obs !== E_FETCH1) begin bad++; $display("FAIL beq_done got=%b exp=%b", obs, E_FETCH1); end
        total++;
        step(); step();
        if (obs !== E_JMP) begin bad++; $display("FAIL j_exec got=%b exp=%b", obs, E_JMP); end
        total++;
        step();
        if (obs !== E_FETCH1) begin bad++; $display("FAIL j_done got=%b exp=%b", obs, E_FETCH1); end
        total++;
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; mem_ready = 1'b1; #1;
        step();
        if (obs !== E_DECILL) begin bad++; $display("FAIL ill_decode got=%b exp=%b", obs, E_DECILL); end
        total++;
        step();
        if (obs !== E_FETCH1) begin bad++; $display("FAIL ill_done got=%b exp=%b", obs, E_FETCH1); end
        total++;
    endtask

    task automatic test_addi();
        opcode = 6'b001000; mem_ready = 1'b1; #1;
        step();
`ifdef MIPS_CTRL_ADDI_EN
        if (obs !== E_DEC) begin bad++; $display("FAIL addi_decode got=%b exp=%b", obs, E_DEC); end
        total++;
        step();
        if (obs !== E_AEX) begin bad++; $display("FAIL addi_ex got=%b exp=%b", obs, E_AEX); end
        total++;
        step();
        if (obs !== E_AWB) begin bad++; $display("FAIL addi_wb got=%b exp=%b", obs, E_AWB); end
        total++;
`else
        if (obs !== E_DECILL) begin bad++; $display("FAIL addi_illegal got=%b exp=%b", obs, E_DECILL); end
        total++;
`endif
        step();
        if (obs !== E_FETCH1) begin bad++; $display("FAIL addi_done got=%b exp=%b", obs, E_FETCH1); end
        total++;
    endtask

    task automatic test_reset_mid();
        opcode = 6'b101011; mem_ready = 1'b1; #1;
        step(); step();
        mem_ready = 1'b0;
        step();
        if (obs !== E_MWR) begin bad++; $display("FAIL rmid_stall got=%b exp=%b", obs, E_MWR); end
        total++;
        #2 reset = 1'b1;
        #1;
        if (obs !== E_FETCH0) begin bad++; $display("FAIL rmid_async got=%b exp=%b", obs, E_FETCH0); end
        total++;
        #2 reset = 1'b0;
        step();
        if (obs !== E_FETCH0) begin bad++; $display("FAIL rmid_after got=%b exp=%b", obs, E_FETCH0); end
        total++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw();
        test_branch_jump();
        test_illegal();
        test_addi();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
